softsign_core_arbiter: RTL

- Shares one fixed-latency Softsign datapath core among NUM_REQ independent requesters.
- Accepts one element per cycle from the winning requester and forwards it to the core.
- Tags each element with its requester index and routes the core's result back to that requester.
- Sits between per-channel activation streams and the single Softsign core instance.

---
 rtl/softsign_core_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/softsign_core_arbiter.sv
// Round-robin arbiter sharing one fixed-latency Softsign core among NUM_REQ requesters.
// Build option: SOFTSIGN_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module softsign_core_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int CORE_LAT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      core_valid_in,
    output logic [DATA_W-1:0]         core_data_in,
    input  logic                      core_valid_out,
    input  logic [DATA_W-1:0]         core_data_out,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      busy,
    output logic                      err
);

    localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [TW-1:0] tag_t;

    logic [NUM_REQ-1:0] grant;
    tag_t               gidx;
    logic               found;
    logic               xfer;
    logic [DATA_W-1:0]  sel_data;
    tag_t               issue_tag;

    logic [CORE_LAT-1:0] tp_v;
    tag_t                tp_tag [CORE_LAT];
    logic                head_v;
    tag_t                head_tag;

`ifdef SOFTSIGN_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gidx     = tag_t'(i);
            end
        end
    end
`else
    tag_t ptr;

    function automatic int rr_idx(input tag_t p, input int k);
        return (int'(p) + k) % NUM_REQ;
    endfunction

    // Search starts at ptr and wraps, so the last winner gets lowest priority
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[rr_idx(ptr, k)]) begin
                found                 = 1'b1;
                grant[rr_idx(ptr, k)] = 1'b1;
                gidx                  = tag_t'(rr_idx(ptr, k));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            if (int'(gidx) == NUM_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= gidx + tag_t'(1);
            end
        end
    end
`endif

    // No grant may leak out while reset is held
    assign req_ready = rst_n ? grant : '0;
    assign xfer      = rst_n & found;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_valid_in <= 1'b0;
            core_data_in  <= '0;
            issue_tag     <= '0;
        end else begin
            core_valid_in <= xfer;
            if (xfer) begin
                core_data_in <= sel_data;
                issue_tag    <= gidx;
            end
        end
    end

    // Tag pipeline head lines up with core_valid_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_v <= '0;
            for (int k = 0; k < CORE_LAT; k++) begin
                tp_tag[k] <= '0;
            end
        end else begin
            tp_v[0]   <= core_valid_in;
            tp_tag[0] <= issue_tag;
            for (int k = 1; k < CORE_LAT; k++) begin
                tp_v[k]   <= tp_v[k-1];
                tp_tag[k] <= tp_tag[k-1];
            end
        end
    end

    assign head_v   = tp_v[CORE_LAT-1];
    assign head_tag = tp_tag[CORE_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= '0;
            resp_data  <= '0;
            err        <= 1'b0;
        end else begin
            resp_valid <= '0;
            if (core_valid_out && head_v) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    resp_valid[i] <= (head_tag == tag_t'(i));
                end
                resp_data <= core_data_out;
            end
            if (core_valid_out != head_v) begin
                err <= 1'b1;
            end
        end
    end

    assign busy = core_valid_in | (|tp_v) | (|resp_valid);

endmodule
